// File: rtl/conv_layer_sched_pkg.sv
// Shared definitions for the convolution layer scheduler: FSM state encoding,
// error codes, ps_control / pl_status bit positions and descriptor field offsets.
package conv_layer_sched_pkg;

  // Scheduler FSM states (4-bit encoding).
  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_FETCH = 4'd1,
    S_CHECK = 4'd2,
    S_CLR   = 4'd3,
    S_START = 4'd4,
    S_WAIT  = 4'd5,
    S_NEXT  = 4'd6,
    S_DONE  = 4'd7,
    S_ERR   = 4'd8,
    S_ABORT = 4'd9
  } state_e;

  // Error codes reported in pl_status[7:4].
  typedef enum logic [3:0] {
    ERR_NONE       = 4'd0,
    ERR_BAD_DESC   = 4'd1,
    ERR_WDOG       = 4'd2,
    ERR_ZERO_COUNT = 4'd3,
    ERR_OVER_COUNT = 4'd4
  } err_code_e;

  // ps_control bit positions.
  localparam int PS_START_BIT = 0;
  localparam int PS_ABORT_BIT = 1;
  localparam int PS_COUNT_LSB = 8;

  // pl_status bit positions.
  localparam int ST_DONE_BIT  = 0;
  localparam int ST_BUSY_BIT  = 1;
  localparam int ST_ERR_BIT   = 2;
  localparam int ST_ABORT_BIT = 3;
  localparam int ST_CODE_LSB  = 4;
  localparam int ST_LAYER_LSB = 8;

  // Descriptor geometry: three 32-bit words per layer, packed {w2, w1, w0}.
  localparam int DESC_WORDS = 3;
  localparam int W0_LSB     = 0;
  localparam int W1_LSB     = 32;
  localparam int W2_LSB     = 64;

  // Field offsets within each descriptor word.
  localparam int W0_M_LSB           = 24;
  localparam int W0_N_LSB           = 16;
  localparam int W0_K_LSB           = 12;
  localparam int W0_IFM_R_LSB       = 6;
  localparam int W0_IFM_C_LSB       = 0;
  localparam int W1_IFM_BASE_LSB    = 16;
  localparam int W1_KERNEL_BASE_LSB = 0;
  localparam int W2_OFM_BASE_LSB    = 16;
  localparam int W2_FLAG_LAST_BIT   = 0;

  // Decoded view of one layer descriptor.
  typedef struct packed {
    logic [7:0]  m;
    logic [7:0]  n;
    logic [3:0]  k;
    logic [5:0]  ifm_r;
    logic [5:0]  ifm_c;
    logic [15:0] ifm_base;
    logic [15:0] kernel_base;
    logic [15:0] ofm_base;
    logic        last;
  } desc_t;

endpackage

// File: rtl/conv_layer_sched_desc_fetch.sv
// desc_fetch: 4-cycle descriptor read pipeline. Issues the three word
// addresses of one layer on cycles 0-2 and captures the BRAM data (one-cycle
// read latency) on cycles 1-3. 'valid' is high in the cycle the last word is
// captured; 'desc' holds the complete descriptor from the following cycle.
module desc_fetch
  import conv_layer_sched_pkg::*;
#(
  parameter int DESC_BASE   = 0,
  parameter int BYTE_OFFSET = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        go,
  input  logic        cancel,
  input  logic [7:0]  layer,
  input  logic [31:0] rddata,
  output logic [31:0] addr,
  output logic [95:0] desc,
  output logic        valid
);

  logic       active;
  logic [1:0] phase;

  assign valid = active && (phase == 2'd3);

  // Address issue and word capture sequencer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      active <= 1'b0;
      phase  <= 2'd0;
      addr   <= '0;
      desc   <= '0;
    end else if (cancel) begin
      active <= 1'b0;
      phase  <= 2'd0;
    end else if (go) begin
      // Word 0 address is presented in the first FETCH cycle.
      active <= 1'b1;
      phase  <= 2'd0;
      addr   <= 32'(DESC_BASE) + 32'(BYTE_OFFSET) * (32'(DESC_WORDS) * {24'd0, layer});
    end else if (active) begin
      phase <= phase + 2'd1;
      if (phase == 2'd0 || phase == 2'd1) begin
        addr <= addr + 32'(BYTE_OFFSET);
      end
      case (phase)
        2'd1:    desc[W0_LSB +: 32] <= rddata;
        2'd2:    desc[W1_LSB +: 32] <= rddata;
        2'd3:    desc[W2_LSB +: 32] <= rddata;
        default: ;
      endcase
      if (phase == 2'd3) begin
        active <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/conv_layer_sched.sv
// conv_layer_sched: walks the per-layer descriptor table, validates each
// descriptor, programs the engine configuration, pulses eng_start and waits
// for eng_done, reporting progress through pl_status.
// Optional feature: define SCHED_WDOG_EN to bound WAIT with a cycle watchdog
// (WDOG_CYCLES); without it WAIT is unbounded.
module conv_layer_sched
  import conv_layer_sched_pkg::*;
#(
  parameter int MAX_LAYERS  = 16,
  parameter int DESC_BASE   = 0,
  parameter int BYTE_OFFSET = 4,
  parameter int WDOG_CYCLES = 65535
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ps_control,
  output logic [31:0] pl_status,
  output logic [31:0] desc_addr,
  input  logic [31:0] desc_rddata,
  output logic        eng_clr,
  output logic        eng_start,
  input  logic        eng_done,
  output logic [7:0]  cfg_m,
  output logic [7:0]  cfg_n,
  output logic [3:0]  cfg_k,
  output logic [5:0]  cfg_ifm_r,
  output logic [5:0]  cfg_ifm_c,
  output logic [5:0]  cfg_ofm_r,
  output logic [5:0]  cfg_ofm_c,
  output logic [15:0] cfg_ifm_base,
  output logic [15:0] cfg_kernel_base,
  output logic [15:0] cfg_ofm_base
);

  state_e      state;
  err_code_e   err_code;
  logic        start_q;
  logic [7:0]  n_layers;
  logic [7:0]  layer;
  logic        last_flag;
  logic        done_bit;
  logic        err_bit;
  logic        abort_bit;
`ifdef SCHED_WDOG_EN
  logic [31:0] wdog_cnt;
`endif

  logic [7:0]  count_in;
  logic        start_rise;
  logic        cnt_zero;
  logic        cnt_over;
  logic        abort_req;
  logic        last_layer;
  logic        desc_bad;
  logic        busy;
  logic        fetch_go;
  logic [7:0]  fetch_layer;
  logic [95:0] fetch_desc;
  logic        fetch_valid;
  desc_t       d;
  logic        unused_bits;

  assign count_in   = ps_control[PS_COUNT_LSB +: 8];
  assign start_rise = ps_control[PS_START_BIT] && !start_q;
  assign cnt_zero   = (count_in == 8'd0);
  assign cnt_over   = (count_in > 8'(MAX_LAYERS));
  assign abort_req  = ps_control[PS_ABORT_BIT] &&
                      !(state inside {S_IDLE, S_DONE, S_ERR, S_ABORT});
  assign last_layer = ((layer + 8'd1) == n_layers) || last_flag;
  assign busy       = !(state inside {S_IDLE, S_DONE, S_ERR});

  // The fetch pipeline is launched in the cycle the FSM moves into FETCH so
  // that the word 0 address is already on the bus in the first FETCH cycle.
  assign fetch_go    = !abort_req &&
                       ((state == S_IDLE && start_rise && !cnt_zero && !cnt_over) ||
                        (state == S_NEXT && !last_layer));
  assign fetch_layer = (state == S_NEXT) ? (layer + 8'd1) : 8'd0;

  desc_fetch #(
    .DESC_BASE   (DESC_BASE),
    .BYTE_OFFSET (BYTE_OFFSET)
  ) u_fetch (
    .clk    (clk),
    .reset  (reset),
    .go     (fetch_go),
    .cancel (abort_req),
    .layer  (fetch_layer),
    .rddata (desc_rddata),
    .addr   (desc_addr),
    .desc   (fetch_desc),
    .valid  (fetch_valid)
  );

  // Descriptor field decode; only consumed in CHECK.
  assign d.m           = fetch_desc[W0_LSB + W0_M_LSB +: 8];
  assign d.n           = fetch_desc[W0_LSB + W0_N_LSB +: 8];
  assign d.k           = fetch_desc[W0_LSB + W0_K_LSB +: 4];
  assign d.ifm_r       = fetch_desc[W0_LSB + W0_IFM_R_LSB +: 6];
  assign d.ifm_c       = fetch_desc[W0_LSB + W0_IFM_C_LSB +: 6];
  assign d.ifm_base    = fetch_desc[W1_LSB + W1_IFM_BASE_LSB +: 16];
  assign d.kernel_base = fetch_desc[W1_LSB + W1_KERNEL_BASE_LSB +: 16];
  assign d.ofm_base    = fetch_desc[W2_LSB + W2_OFM_BASE_LSB +: 16];
  assign d.last        = fetch_desc[W2_LSB + W2_FLAG_LAST_BIT];

  // A zero dimension or a kernel larger than the input map is rejected; the
  // latter guarantees the output-size subtraction below never wraps.
  assign desc_bad = (d.m == 8'd0) || (d.n == 8'd0) || (d.k == 4'd0) ||
                    ({2'b00, d.k} > d.ifm_r) || ({2'b00, d.k} > d.ifm_c);

  // Reserved control bits and the non-last descriptor flags are don't-cares.
`ifdef SCHED_WDOG_EN
  assign unused_bits = ^{ps_control[31:16], ps_control[7:2],
                         fetch_desc[W2_LSB + 1 +: 15]};
`else
  assign unused_bits = ^{ps_control[31:16], ps_control[7:2],
                         fetch_desc[W2_LSB + 1 +: 15], 32'(WDOG_CYCLES)};
`endif

  // Status word assembly from registered state.
  always_comb begin
    // NOTE: default the whole word first so every bit is assigned on every path and no latch is inferred.
    pl_status                        = '0;
    pl_status[ST_DONE_BIT]           = done_bit;
    pl_status[ST_BUSY_BIT]           = busy;
    pl_status[ST_ERR_BIT]            = err_bit;
    pl_status[ST_ABORT_BIT]          = abort_bit;
    pl_status[ST_CODE_LSB +: 4]      = err_code;
    pl_status[ST_LAYER_LSB +: 8]     = layer;
  end

  // Scheduler FSM with registered engine controls, configuration and status.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= S_IDLE;
      err_code        <= ERR_NONE;
      start_q         <= 1'b0;
      n_layers        <= '0;
      layer           <= '0;
      last_flag       <= 1'b0;
      done_bit        <= 1'b0;
      err_bit         <= 1'b0;
      abort_bit       <= 1'b0;
      eng_clr         <= 1'b0;
      eng_start       <= 1'b0;
      cfg_m           <= '0;
      cfg_n           <= '0;
      cfg_k           <= '0;
      cfg_ifm_r       <= '0;
      cfg_ifm_c       <= '0;
      cfg_ofm_r       <= '0;
      cfg_ofm_c       <= '0;
      cfg_ifm_base    <= '0;
      cfg_kernel_base <= '0;
      cfg_ofm_base    <= '0;
`ifdef SCHED_WDOG_EN
      wdog_cnt        <= '0;
`endif
    end else begin
      start_q   <= ps_control[PS_START_BIT];
      // NOTE: non-blocking defaults make the pulses one cycle wide; a later assignment in this block overrides them.
      eng_clr   <= 1'b0;
      eng_start <= 1'b0;

      if (abort_req) begin
        // Abort wins over everything, including a simultaneous eng_done.
        state     <= S_ABORT;
        eng_clr   <= 1'b1;
        abort_bit <= 1'b1;
      end else begin
        unique case (state)
          S_IDLE: begin
            if (start_rise) begin
              n_layers  <= count_in;
              layer     <= '0;
              err_bit   <= 1'b0;
              abort_bit <= 1'b0;
              err_code  <= ERR_NONE;
              if (cnt_zero) begin
                state    <= S_ERR;
                err_bit  <= 1'b1;
                err_code <= ERR_ZERO_COUNT;
              end else if (cnt_over) begin
                state    <= S_ERR;
                err_bit  <= 1'b1;
                err_code <= ERR_OVER_COUNT;
              end else begin
                state <= S_FETCH;
              end
            end
          end
          S_FETCH: begin
            if (fetch_valid) state <= S_CHECK;
          end
          S_CHECK: begin
            if (desc_bad) begin
              state    <= S_ERR;
              err_bit  <= 1'b1;
              err_code <= ERR_BAD_DESC;
            end else begin
              cfg_m           <= d.m;
              cfg_n           <= d.n;
              cfg_k           <= d.k;
              cfg_ifm_r       <= d.ifm_r;
              cfg_ifm_c       <= d.ifm_c;
              cfg_ofm_r       <= d.ifm_r - {2'b00, d.k} + 6'd1;
              cfg_ofm_c       <= d.ifm_c - {2'b00, d.k} + 6'd1;
              cfg_ifm_base    <= d.ifm_base;
              cfg_kernel_base <= d.kernel_base;
              cfg_ofm_base    <= d.ofm_base;
              last_flag       <= d.last;
              eng_clr         <= 1'b1;
              state           <= S_CLR;
            end
          end
          S_CLR: begin
            eng_start <= 1'b1;
            state     <= S_START;
          end
          S_START: begin
`ifdef SCHED_WDOG_EN
            wdog_cnt <= '0;
`endif
            state <= S_WAIT;
          end
          S_WAIT: begin
            if (eng_done) begin
              state <= S_NEXT;
`ifdef SCHED_WDOG_EN
            end else if (wdog_cnt == 32'(WDOG_CYCLES - 1)) begin
              state    <= S_ERR;
              err_bit  <= 1'b1;
              err_code <= ERR_WDOG;
              eng_clr  <= 1'b1;
            end else begin
              wdog_cnt <= wdog_cnt + 32'd1;
`endif
            end
          end
          S_NEXT: begin
            layer <= layer + 8'd1;
            if (last_layer) begin
              state    <= S_DONE;
              done_bit <= 1'b1;
            end else begin
              state <= S_FETCH;
            end
          end
          S_DONE: begin
            if (!ps_control[PS_START_BIT]) begin
              state    <= S_IDLE;
              done_bit <= 1'b0;
            end
          end
          S_ERR: begin
            if (!ps_control[PS_START_BIT]) state <= S_IDLE;
          end
          S_ABORT: begin
            state <= S_IDLE;
          end
          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_conv_layer_sched.sv
// Directed testbench for conv_layer_sched: descriptor BRAM model with one-cycle
// read latency, hand-driven eng_done, immediate-assertion checks.
module tb_conv_layer_sched;

  logic        clk;
  logic        reset;
  logic [31:0] ps_control;
  logic [31:0] pl_status;
  logic [31:0] desc_addr;
  logic [31:0] desc_rddata;
  logic        eng_clr;
  logic        eng_start;
  logic        eng_done;
  logic [7:0]  cfg_m;
  logic [7:0]  cfg_n;
  logic [3:0]  cfg_k;
  logic [5:0]  cfg_ifm_r;
  logic [5:0]  cfg_ifm_c;
  logic [5:0]  cfg_ofm_r;
  logic [5:0]  cfg_ofm_c;
  logic [15:0] cfg_ifm_base;
  logic [15:0] cfg_kernel_base;
  logic [15:0] cfg_ofm_base;

  logic [31:0] mem [0:63];
  int          tests = 0;
  int          fails = 0;
  int          start_cnt = 0;
  logic [31:0] max_addr = '0;

  conv_layer_sched #(
    .MAX_LAYERS  (16),
    .DESC_BASE   (0),
    .BYTE_OFFSET (4),
    .WDOG_CYCLES (100)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .ps_control      (ps_control),
    .pl_status       (pl_status),
    .desc_addr       (desc_addr),
    .desc_rddata     (desc_rddata),
    .eng_clr         (eng_clr),
    .eng_start       (eng_start),
    .eng_done        (eng_done),
    .cfg_m           (cfg_m),
    .cfg_n           (cfg_n),
    .cfg_k           (cfg_k),
    .cfg_ifm_r       (cfg_ifm_r),
    .cfg_ifm_c       (cfg_ifm_c),
    .cfg_ofm_r       (cfg_ofm_r),
    .cfg_ofm_c       (cfg_ofm_c),
    .cfg_ifm_base    (cfg_ifm_base),
    .cfg_kernel_base (cfg_kernel_base),
    .cfg_ofm_base    (cfg_ofm_base)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Descriptor BRAM with one-cycle read latency.
  always @(posedge clk) desc_rddata <= mem[desc_addr[7:2]];

  // Count engine start pulses and track the highest descriptor address seen.
  always @(negedge clk) begin
    if (eng_start === 1'b1) start_cnt++;
    if (desc_addr > max_addr) max_addr = desc_addr;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Advance until eng_start is seen, bounded; 'cycles' starts at 'first'.
  task automatic wait_start(input int first, output int cycles);
    cycles = first;
    while (eng_start !== 1'b1 && cycles < 60) begin
      tick(1);
      cycles++;
    end
  endtask

  initial begin
    int c;
    int base;

    reset      = 1'b0;
    ps_control = '0;
    eng_done   = 1'b0;
    for (int i = 0; i < 64; i++) mem[i] = '0;

    // Reset state
    tick(2);
    check("rst_status", pl_status, 32'h0);
    check("rst_addr", desc_addr, 32'h0);
    check("rst_ctrl", {30'd0, eng_start, eng_clr}, 32'h0);
    check("rst_cfg", {cfg_m, cfg_n, cfg_k, cfg_ofm_r, cfg_ofm_c}, 32'h0);
    check("rst_bases", {cfg_ifm_base, cfg_ofm_base}, 32'h0);
    reset = 1'b1;
    tick(2);

    // Test 1: single layer, 3x3 kernel on 4x4, last flag set
    mem[0] = 32'h0303_3104;
    mem[1] = 32'h0000_0000;
    mem[2] = 32'h0000_0001;
    ps_control = 32'h0000_0101;
    wait_start(0, c);
    check("t1_start_latency", c, 7);
    check("t1_ofm_r", cfg_ofm_r, 2);
    check("t1_ofm_c", cfg_ofm_c, 2);
    check("t1_m", cfg_m, 3);
    check("t1_busy", pl_status, 32'h0000_0002);
    tick(3);
    eng_done = 1'b1;
    tick(1);
    eng_done = 1'b0;
    check("t1_not_done_yet", pl_status[0], 0);
    tick(1);
    check("t1_done", pl_status, 32'h0000_0101);
    ps_control = 32'h0;
    tick(1);
    check("t1_idle", pl_status, 32'h0000_0100);

    // Test 2: three layers, no last flags, 8-cycle inter-layer gaps
    mem[0] = 32'h0804_1206; mem[1] = 32'h0010_0020; mem[2] = 32'h0030_0000;
    mem[3] = 32'h0101_4104; mem[4] = 32'h1111_2222; mem[5] = 32'h3333_0000;
    mem[6] = 32'hFFFF_FFE8; mem[7] = 32'h1234_5678; mem[8] = 32'h9ABC_0000;
    base = start_cnt;
    ps_control = 32'h0000_0301;
    wait_start(0, c);
    check("t2_l0_latency", c, 7);
    check("t2_l0_ofm", {26'd0, cfg_ofm_r}, 8);
    check("t2_l0_ofm_c", {26'd0, cfg_ofm_c}, 6);
    check("t2_l0_n", cfg_n, 4);
    check("t2_l0_bases", {cfg_ifm_base, cfg_kernel_base}, 32'h0010_0020);
    check("t2_l0_ofm_base", cfg_ofm_base, 16'h0030);
    tick(2);
    eng_done = 1'b1;
    tick(1);
    eng_done = 1'b0;
    wait_start(1, c);
    check("t2_gap01", c, 8);
    check("t2_l1_ofm", {cfg_ofm_r, cfg_ofm_c}, 12'h041);
    check("t2_l1_k", cfg_k, 4);
    check("t2_l1_bases", {cfg_ifm_base, cfg_kernel_base}, 32'h1111_2222);
    check("t2_l1_ofm_base", cfg_ofm_base, 16'h3333);
    tick(2);
    // Done is left high through NEXT..START as a stale level
    eng_done = 1'b1;
    wait_start(0, c);
    eng_done = 1'b0;
    check("t2_gap12", c, 8);
    check("t2_l2_m", cfg_m, 255);
    check("t2_l2_ofm_r", cfg_ofm_r, 49);
    check("t2_l2_ofm_c", cfg_ofm_c, 26);
    check("t2_l2_bases", {cfg_ifm_base, cfg_kernel_base}, 32'h1234_5678);
    check("t2_l2_ofm_base", cfg_ofm_base, 16'h9ABC);
    tick(3);
    check("t2_stale_done_ignored", pl_status, 32'h0000_0202);
    eng_done = 1'b1;
    tick(1);
    eng_done = 1'b0;
    tick(1);
    check("t2_done", pl_status, 32'h0000_0301);
    check("t2_starts", start_cnt - base, 3);
    check("t2_max_addr", max_addr, 32);
    ps_control = 32'h0;
    tick(1);

    // Test 3: layer 1 has k=5 > ifm_r=4
    mem[3] = 32'h0101_5108;
    base = start_cnt;
    ps_control = 32'h0000_0301;
    wait_start(0, c);
    tick(2);
    eng_done = 1'b1;
    tick(1);
    eng_done = 1'b0;
    tick(6);
    check("t3_err", pl_status, 32'h0000_0114);
    tick(1);
    check("t3_addr", desc_addr, 20);
    tick(10);
    check("t3_one_start", start_cnt - base, 1);
    check("t3_err_held", pl_status, 32'h0000_0114);
    ps_control = 32'h0;
    tick(1);
    check("t3_err_after_idle", pl_status, 32'h0000_0114);

    // Test 4: zero and overflow layer counts, no descriptor reads
    ps_control = 32'h0000_0001;
    tick(1);
    check("t4_zero", pl_status, 32'h0000_0034);
    check("t4_zero_addr", desc_addr, 20);
    ps_control = 32'h0;
    tick(1);
    ps_control = 32'h0000_1101;
    tick(1);
    check("t4_over", pl_status, 32'h0000_0044);
    check("t4_over_addr", desc_addr, 20);
    ps_control = 32'h0;
    tick(1);

    // Test 5: abort in WAIT together with eng_done
    ps_control = 32'h0000_0101;
    tick(1);
    check("t5_err_cleared", pl_status, 32'h0000_0002);
    wait_start(1, c);
    tick(2);
    eng_done   = 1'b1;
    ps_control = 32'h0000_0103;
    tick(1);
    check("t5_abort_clr", eng_clr, 1);
    check("t5_abort_status", pl_status, 32'h0000_000A);
    eng_done   = 1'b0;
    ps_control = 32'h0;
    tick(1);
    check("t5_clr_one_cycle", eng_clr, 0);
    check("t5_idle_aborted", pl_status, 32'h0000_0008);
    ps_control = 32'h0000_0101;
    tick(1);
    check("t5_abort_cleared", pl_status, 32'h0000_0002);
    wait_start(1, c);
    check("t5_restart_latency", c, 7);
    tick(1);
    eng_done = 1'b1;
    tick(1);
    eng_done = 1'b0;
    tick(1);
    check("t5_done", pl_status, 32'h0000_0101);
    ps_control = 32'h0;
    tick(1);

`ifdef SCHED_WDOG_EN
    // Test 6: watchdog expiry with eng_done held low
    ps_control = 32'h0000_0101;
    wait_start(0, c);
    tick(100);
    check("t6_still_waiting", pl_status, 32'h0000_0002);
    tick(1);
    check("t6_wdog_err", pl_status, 32'h0000_0024);
    check("t6_wdog_clr", eng_clr, 1);
    tick(1);
    check("t6_wdog_clr_pulse", eng_clr, 0);
    ps_control = 32'h0;
    tick(1);
`endif

    // Test 7: asynchronous reset in the middle of a run
    ps_control = 32'h0000_0101;
    wait_start(0, c);
    tick(1);
    reset = 1'b0;
    #2;
    check("t7_rst_status", pl_status, 32'h0);
    check("t7_rst_cfg", {cfg_m, cfg_ofm_r, cfg_ofm_c, 7'd0, eng_clr}, 32'h0);
    check("t7_rst_addr", desc_addr, 32'h0);
    ps_control = 32'h0;
    reset = 1'b1;
    tick(1);
    check("t7_after_rst", pl_status, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/conv_layer_sched.md
# conv_layer_sched

Layer scheduler for the convolution multiply engine. It walks a table of per-layer descriptors in a descriptor BRAM, validates each descriptor, and drives the engine's configuration registers. It then pulses the engine's start, waits for its done, and reports progress to the PS over the same `ps_control`/`pl_status` word convention used by the engine wrapper. It sits between the PS register interface and the engine.

## Interface
- `MAX_LAYERS`, 16: descriptor table capacity.
- `DESC_BASE`, 0: byte address of descriptor 0.
- `BYTE_OFFSET`, 4: bytes per 32-bit word.
- `WDOG_CYCLES`, 65535: watchdog limit. Only used with `SCHED_WDOG_EN`.
- `clk` in 1: single clock.
- `reset` in 1: reset, asynchronous, active-low.
- `ps_control` in 32: bit0 start, bit1 abort, [15:8] layer count.
- `pl_status` out 32: bit0 done, bit1 busy, bit2 error, bit3 aborted, [7:4] error code, [15:8] current layer index.
- `desc_addr` out 32: descriptor BRAM byte address.
- `desc_rddata` in 32: descriptor data, one-cycle read latency.
- `eng_clr` out 1: clears the engine's counters.
- `eng_start` out 1: one-cycle start pulse.
- `eng_done` in 1: engine completion, level-sensitive.
- `cfg_m`, `cfg_n` out 8 each.
- `cfg_k` out 4.
- `cfg_ifm_r`, `cfg_ifm_c`, `cfg_ofm_r`, `cfg_ofm_c` out 6 each.
- `cfg_ifm_base`, `cfg_kernel_base`, `cfg_ofm_base` out 16 each: word addresses.

## Operation
- Descriptor layout: 3 words per layer, word address 3·L+w.
  - w0 = {m[31:24], n[23:16], k[15:12], ifm_r[11:6], ifm_c[5:0]}.
  - w1 = {ifm_base[31:16], kernel_base[15:0]}.
  - w2 = {ofm_base[31:16], flags[15:0]}, where flags bit0 means last layer.
- `desc_addr` = DESC_BASE + BYTE_OFFSET·(3·L+w).
- States: IDLE → FETCH → CHECK → CLR → START → WAIT → NEXT → (FETCH | DONE). ERR and ABORT are reachable as below.
- IDLE: a rising edge of `ps_control[0]` latches the count N = `ps_control[15:8]` and sets L=0.
  - N=0 goes to ERR, code 3.
  - N>MAX_LAYERS goes to ERR, code 4.
  - Otherwise goes to FETCH.
- FETCH, 4 cycles:
  - Addresses for w0, w1, w2 are issued on cycles 0–2.
  - Words are captured on cycles 1–3.
- CHECK, 1 cycle. Goes to ERR, code 1, if any of: m=0, n=0, k=0, k>ifm_r, or k>ifm_c.
  - On pass, computes `cfg_ofm_r` = ifm_r−k+1 and `cfg_ofm_c` = ifm_c−k+1 as 6-bit unsigned values (the check guarantees no wrap).
  - All `cfg_*` outputs are registered here and held until the next CHECK pass.
- CLR: `eng_clr`=1 for exactly 1 cycle.
- START: `eng_start`=1 for exactly 1 cycle.
- WAIT: holds until `eng_done`=1.
- NEXT: increments L.
  - If L+1==N or the flags last bit was set, goes to DONE.
  - Otherwise goes to FETCH.
- DONE: `pl_status` bit0=1. Holds until `ps_control[0]`=0, then returns to IDLE.
- ERR: error bit and code held. Leaves to IDLE only when `ps_control[0]`=0.
- Abort: `ps_control[1]`=1 in any state other than IDLE/DONE/ERR goes to ABORT.
  - ABORT drives `eng_clr`=1 for 1 cycle, sets bit3, then goes to IDLE.
  - Abort takes priority over a simultaneous `eng_done`.
- Error and aborted bits clear on the next accepted start.
- Busy (bit1) = state ∉ {IDLE, DONE, ERR}.

## Timing
- Reset (`reset`=0, async): state IDLE; all outputs 0, including every `cfg_*`, `desc_addr`, `eng_start`, `eng_clr` and `pl_status`.
- Start edge to first `desc_addr` issue: 1 cycle.
- Start edge to `eng_start`: 7 cycles (FETCH 4, CHECK 1, CLR 1, START 1).
- `eng_done` is sampled in WAIT only. A stale `eng_done` seen in CLR is ignored, because the engine drops done on clr.
- Inter-layer gap, from `eng_done` in WAIT to the next `eng_start`: 8 cycles.
- Mid-run reset: immediate return to IDLE. Engine state is not touched beyond `eng_clr`=0.

## Configuration
- `SCHED_WDOG_EN`: adds a 32-bit cycle counter in WAIT.
  - The counter is cleared on entry to WAIT.
  - Reaching WDOG_CYCLES goes to ERR, code 2, with `eng_clr` pulsed for 1 cycle.
- Without the macro: no counter, WAIT is unbounded, and code 2 never occurs.

## Structure
- Shared package holds:
  - state encoding (4-bit);
  - error codes: 1 bad descriptor, 2 watchdog, 3 zero count, 4 overflow count;
  - `pl_status` bit positions;
  - descriptor field offsets.
- One sub-module, `desc_fetch`: the 4-cycle address/capture pipeline, producing a 96-bit descriptor and a valid pulse.

## Test plan
- N=1, descriptor {m=3, n=3, k=3, 4×4, bases 0/0/0, last=1} → `cfg_ofm_r`=`cfg_ofm_c`=2. `eng_start` 7 cycles after the start edge; done bit set 2 cycles after `eng_done`.
- N=3 with no last flags → exactly 3 `eng_start` pulses, 8-cycle gaps, `desc_addr` reaching DESC_BASE+32, then done with index field = 3.
- N=3, layer 1 has k=5 with ifm_r=4 → ERR code 1 after 1 engine run; no second `eng_start`.
- N=0 → ERR code 3. N=17 → ERR code 4. No descriptor read in either case.
- Abort asserted in WAIT on the same cycle as `eng_done` → 1-cycle `eng_clr`, aborted bit set, IDLE; a fresh start edge clears the bit.
- `SCHED_WDOG_EN` with WDOG_CYCLES=100 and `eng_done` held low → ERR code 2 exactly 100 cycles after WAIT entry.
